// File: rtl/mem_io_bridge_if.sv
// mem_io_bridge_if: bundles the CPU load/store request, the data-memory port and the IO channel
// port of mem_io_bridge.
//   CPU side   : iReq, iWrite, iSize, iUnsigned, iAddr, iWData -> oStall, oValid, oRData, oError
//   Memory side: oMemAddr, oMemRead, oMemWrite, oMemByteEn, oMemWData <- iMemRData
//   IO side    : oIoCs, oIoRead, oIoWrite, oIoWData <- iIoRData (channel k at [k*IO_DATA_W +:])
// Modport slave is taken by the bridge; modport master by whatever drives the CPU request and
// models memory/IO.
interface mem_io_bridge_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned N_IO_CH   = 4,
    parameter int unsigned IO_DATA_W = 16
);
    logic                           iReq;
    logic                           iWrite;
    logic [1:0]                     iSize;
    logic                           iUnsigned;
    logic [ADDR_W-1:0]              iAddr;
    logic [31:0]                    iWData;
    logic                           oStall;
    logic                           oValid;
    logic [31:0]                    oRData;
    logic                           oError;
    logic [ADDR_W-1:0]              oMemAddr;
    logic                           oMemRead;
    logic                           oMemWrite;
    logic [3:0]                     oMemByteEn;
    logic [31:0]                    oMemWData;
    logic [31:0]                    iMemRData;
    logic [N_IO_CH-1:0]             oIoCs;
    logic                           oIoRead;
    logic                           oIoWrite;
    logic [IO_DATA_W-1:0]           oIoWData;
    logic [N_IO_CH*IO_DATA_W-1:0]   iIoRData;

    modport slave (
        input  iReq, iWrite, iSize, iUnsigned, iAddr, iWData, iMemRData, iIoRData,
        output oStall, oValid, oRData, oError, oMemAddr, oMemRead, oMemWrite, oMemByteEn,
               oMemWData, oIoCs, oIoRead, oIoWrite, oIoWData
    );

    modport master (
        output iReq, iWrite, iSize, iUnsigned, iAddr, iWData, iMemRData, iIoRData,
        input  oStall, oValid, oRData, oError, oMemAddr, oMemRead, oMemWrite, oMemByteEn,
               oMemWData, oIoCs, oIoRead, oIoWrite, oIoWData
    );
endinterface

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: sequences CPU loads/stores to data memory (addr < IO_BASE) or to one of
// N_IO_CH memory-mapped IO channels (addr >= IO_BASE), with lane steering, load extension and
// error reporting. All bus outputs are registered.
// Ports:
//   iClock  - system clock, rising edge
//   iResetN - asynchronous active-low reset
//   bus     - mem_io_bridge_if.slave (CPU request/response, memory port, IO port)
module mem_io_bridge #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] IO_BASE     = 32'hFFFFFC00,
    parameter int unsigned       N_IO_CH     = 4,
    parameter int unsigned       IO_CH_SHIFT = 4,
    parameter int unsigned       IO_DATA_W   = 16,
    parameter int unsigned       MEM_LATENCY = 1
) (
    input  logic              iClock,
    input  logic              iResetN,
    mem_io_bridge_if.slave    bus
);
    localparam int unsigned CH_W  = (N_IO_CH > 1) ? $clog2(N_IO_CH) : 1;
    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StMemWait, StIoAcc, StResp} state_e;

    state_e           state;
    logic [CNT_W-1:0] waitCnt;
    logic             rWrite;
    logic [1:0]       rSize;
    logic             rUnsigned;
    logic [1:0]       rAddrLo;
    logic [CH_W-1:0]  rChan;

    // Request decode straight from the CPU inputs; only used on the acceptance cycle.
    logic              reqIsIo;
    logic [ADDR_W-1:0] reqChan;
    logic              reqErr;
    logic [3:0]        reqByteEn;
    logic [31:0]       reqWData;
    logic [N_IO_CH-1:0] reqCs;

    always_comb begin
        reqIsIo = (bus.iAddr >= IO_BASE);
        reqChan = (bus.iAddr - IO_BASE) >> IO_CH_SHIFT;
        reqErr  = (bus.iSize == 2'd3) ||
                  ((bus.iSize == 2'd1) && bus.iAddr[0]) ||
                  ((bus.iSize == 2'd2) && (bus.iAddr[1:0] != 2'b00)) ||
                  (reqIsIo && (reqChan >= ADDR_W'(N_IO_CH)));
        case (bus.iSize)
            2'd0: begin
                reqByteEn = 4'b0001 << bus.iAddr[1:0];
                reqWData  = {4{bus.iWData[7:0]}};
            end
            2'd1: begin
                reqByteEn = bus.iAddr[1] ? 4'b1100 : 4'b0011;
                reqWData  = {2{bus.iWData[15:0]}};
            end
            default: begin
                reqByteEn = 4'b1111;
                reqWData  = bus.iWData;
            end
        endcase
        for (int k = 0; k < N_IO_CH; k++) begin
            reqCs[k] = (reqChan == ADDR_W'(k));
        end
    end

    // Shift the addressed byte/half down to bit 0 (halfword offsets are 0 or 2), then extend.
    function automatic logic [31:0] extendMem(logic [31:0] word, logic [1:0] size,
                                              logic [1:0] lo, logic uns);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (size)
            2'd0:    return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    logic [IO_DATA_W-1:0] ioSlice;
    logic [31:0]          ioExt;
    always_comb begin
        ioSlice = bus.iIoRData[rChan*IO_DATA_W +: IO_DATA_W];
        ioExt   = rUnsigned ? 32'(ioSlice) : 32'($signed(ioSlice));
    end

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state          <= StIdle;
            waitCnt        <= '0;
            rWrite         <= 1'b0;
            rSize          <= 2'd0;
            rUnsigned      <= 1'b0;
            rAddrLo        <= 2'd0;
            rChan          <= '0;
            bus.oStall     <= 1'b0;
            bus.oValid     <= 1'b0;
            bus.oRData     <= '0;
            bus.oError     <= 1'b0;
            bus.oMemAddr   <= '0;
            bus.oMemRead   <= 1'b0;
            bus.oMemWrite  <= 1'b0;
            bus.oMemByteEn <= '0;
            bus.oMemWData  <= '0;
            bus.oIoCs      <= '0;
            bus.oIoRead    <= 1'b0;
            bus.oIoWrite   <= 1'b0;
            bus.oIoWData   <= '0;
        end else begin
            case (state)
                StIdle, StResp: begin
                    bus.oValid <= 1'b0;
                    bus.oError <= 1'b0;
                    state      <= StIdle;
                    if (bus.iReq) begin
                        rWrite    <= bus.iWrite;
                        rSize     <= bus.iSize;
                        rUnsigned <= bus.iUnsigned;
                        rAddrLo   <= bus.iAddr[1:0];
                        rChan     <= CH_W'(reqChan);
                        if (reqErr) begin
                            // Straight to the response with no strobe.
                            state      <= StResp;
                            bus.oValid <= 1'b1;
                            bus.oError <= 1'b1;
                            bus.oRData <= '0;
                        end else if (reqIsIo) begin
                            state        <= StIoAcc;
                            bus.oStall   <= 1'b1;
                            bus.oIoCs    <= reqCs;
                            bus.oIoRead  <= !bus.iWrite;
                            bus.oIoWrite <= bus.iWrite;
                            bus.oIoWData <= bus.iWData[IO_DATA_W-1:0];
                        end else begin
                            state          <= StMemWait;
                            waitCnt        <= CNT_W'(MEM_LATENCY - 1);
                            bus.oStall     <= 1'b1;
                            bus.oMemAddr   <= {bus.iAddr[ADDR_W-1:2], 2'b00};
                            bus.oMemRead   <= !bus.iWrite;
                            bus.oMemWrite  <= bus.iWrite;
                            bus.oMemByteEn <= reqByteEn;
                            bus.oMemWData  <= reqWData;
                        end
                    end
                end
                StMemWait: begin
                    if (waitCnt == '0) begin
                        state         <= StResp;
                        bus.oStall    <= 1'b0;
                        bus.oMemRead  <= 1'b0;
                        bus.oMemWrite <= 1'b0;
                        bus.oValid    <= 1'b1;
                        if (!rWrite) begin
                            bus.oRData <= extendMem(bus.iMemRData, rSize, rAddrLo, rUnsigned);
                        end
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                StIoAcc: begin
                    state        <= StResp;
                    bus.oStall   <= 1'b0;
                    bus.oIoCs    <= '0;
                    bus.oIoRead  <= 1'b0;
                    bus.oIoWrite <= 1'b0;
                    bus.oValid   <= 1'b1;
                    if (!rWrite) begin
                        bus.oRData <= ioExt;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge (MEM_LATENCY=2, 4 IO channels of 16 bits).
module tb_mem_io_bridge;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    mem_io_bridge_if #(.ADDR_W(32), .N_IO_CH(4), .IO_DATA_W(16)) bus ();

    mem_io_bridge #(
        .ADDR_W(32), .IO_BASE(32'hFFFFFC00), .N_IO_CH(4), .IO_CH_SHIFT(4),
        .IO_DATA_W(16), .MEM_LATENCY(2)
    ) dut (
        .iClock(clk), .iResetN(rstN), .bus(bus)
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    logic [31:0] resData, resMemAddr, resBe, resWData, resCs, resIoWData;
    logic        resErr;
    int          nMemRd, nMemWr, nIoRd, nIoWr, nStall, nCyc;
    bit          timedOut;

    // Presents one request, scrambles the inputs once it is taken, then samples on negedges
    // until the completion pulse. Returns right at the RESP negedge so a follow-up call is
    // accepted back-to-back.
    task automatic runAccess(input logic wr, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.iReq = 1'b1; bus.iWrite = wr; bus.iSize = size; bus.iUnsigned = uns;
        bus.iAddr = addr; bus.iWData = wdata;
        @(posedge clk); #1;
        bus.iReq = 1'b0; bus.iAddr = 32'h5555_5554; bus.iWData = 32'hDEAD_BEEF;
        bus.iSize = 2'd0; bus.iUnsigned = ~uns; bus.iWrite = ~wr;
        nMemRd = 0; nMemWr = 0; nIoRd = 0; nIoWr = 0; nStall = 0; nCyc = 0;
        resCs = 0; resIoWData = 0; resMemAddr = 0; resBe = 0; resWData = 0;
        timedOut = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            nCyc++;
            if (bus.oStall) nStall++;
            if (bus.oMemRead) begin nMemRd++; resMemAddr = bus.oMemAddr; end
            if (bus.oMemWrite) begin
                nMemWr++; resMemAddr = bus.oMemAddr;
                resBe = 32'(bus.oMemByteEn); resWData = bus.oMemWData;
            end
            if (bus.oIoRead) nIoRd++;
            if (bus.oIoWrite) nIoWr++;
            if (bus.oIoRead || bus.oIoWrite) begin
                resCs = 32'(bus.oIoCs); resIoWData = 32'(bus.oIoWData);
            end
            if (bus.oValid) begin
                resData = bus.oRData; resErr = bus.oError; timedOut = 1'b0;
                break;
            end
        end
        checkVal("complete", 32'(!timedOut), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int seen;

    initial begin
        bus.iReq = 1'b0; bus.iWrite = 1'b0; bus.iSize = 2'd0; bus.iUnsigned = 1'b0;
        bus.iAddr = '0; bus.iWData = '0; bus.iMemRData = '0; bus.iIoRData = '0;

        #12;
        checkVal("rst_stall", 32'(bus.oStall), 0);
        checkVal("rst_valid", 32'(bus.oValid), 0);
        checkVal("rst_strobes", 32'({bus.oMemRead, bus.oMemWrite, bus.oIoRead, bus.oIoWrite}), 0);
        checkVal("rst_cs", 32'(bus.oIoCs), 0);
        checkVal("rst_rdata", bus.oRData, 0);
        checkVal("rst_memaddr", bus.oMemAddr, 0);
        checkVal("rst_be", 32'(bus.oMemByteEn), 0);
        @(negedge clk) rstN = 1'b1;
        idle(1);

        // Word load, latency 2
        bus.iMemRData = 32'h8000_00F0;
        runAccess(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checkVal("wload_data", resData, 32'h8000_00F0);
        checkVal("wload_rdcyc", nMemRd, 2);
        checkVal("wload_stall", nStall, 2);
        checkVal("wload_err", 32'(resErr), 0);
        checkVal("wload_addr", resMemAddr, 32'h10);
        checkVal("wload_wr", nMemWr, 0);
        idle(1);

        // Sub-word loads from 0x80FF1234
        bus.iMemRData = 32'h80FF_1234;
        runAccess(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        checkVal("lb_s_13", resData, 32'hFFFF_FF80);
        idle(1);
        runAccess(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        checkVal("lb_u_13", resData, 32'h0000_0080);
        idle(1);
        runAccess(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
        checkVal("lb_s_12", resData, 32'hFFFF_FFFF);
        idle(1);
        runAccess(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
        checkVal("lh_u_10", resData, 32'h0000_1234);
        idle(1);
        runAccess(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        checkVal("lh_s_12", resData, 32'hFFFF_80FF);
        idle(1);

        // Stores
        runAccess(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_ABCD);
        checkVal("sh_wdata", resWData, 32'hABCD_ABCD);
        checkVal("sh_be", resBe, 32'hC);
        checkVal("sh_wrcyc", nMemWr, 2);
        checkVal("sh_rdcyc", nMemRd, 0);
        checkVal("sh_addr", resMemAddr, 32'h20);
        checkVal("sh_keep_rdata", resData, 32'hFFFF_80FF);
        idle(1);
        runAccess(1'b1, 2'd0, 1'b0, 32'h21, 32'h1234_565A);
        checkVal("sb_wdata", resWData, 32'h5A5A_5A5A);
        checkVal("sb_be", resBe, 32'h2);
        idle(1);

        // IO channels
        bus.iIoRData = {16'h4444, 16'h8001, 16'h2222, 16'h1111};
        runAccess(1'b0, 2'd2, 1'b0, 32'hFFFF_FC20, 32'h0);
        checkVal("io_rd_cs", resCs, 32'h4);
        checkVal("io_rd_pulse", nIoRd, 1);
        checkVal("io_rd_stall", nStall, 1);
        checkVal("io_rd_data", resData, 32'hFFFF_8001);
        checkVal("io_rd_nomem", nMemRd + nMemWr, 0);
        idle(1);
        runAccess(1'b0, 2'd0, 1'b1, 32'hFFFF_FC20, 32'h0);
        checkVal("io_rd_u_data", resData, 32'h0000_8001);
        idle(1);
        runAccess(1'b1, 2'd2, 1'b0, 32'hFFFF_FC10, 32'h1234_5678);
        checkVal("io_wr_cs", resCs, 32'h2);
        checkVal("io_wr_pulse", nIoWr, 1);
        checkVal("io_wr_nord", nIoRd, 0);
        checkVal("io_wr_data", resIoWData, 32'h5678);
        idle(1);

        // Errors
        runAccess(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
        checkVal("mis_w_err", 32'(resErr), 1);
        checkVal("mis_w_rdata", resData, 0);
        checkVal("mis_w_strobes", nMemRd + nMemWr + nIoRd + nIoWr, 0);
        checkVal("mis_w_stall", nStall, 0);
        checkVal("mis_w_cyc", nCyc, 1);
        idle(1);
        runAccess(1'b0, 2'd2, 1'b0, 32'hFFFF_FC40, 32'h0);
        checkVal("bad_ch_err", 32'(resErr), 1);
        checkVal("bad_ch_strobes", nMemRd + nMemWr + nIoRd + nIoWr, 0);
        idle(1);
        runAccess(1'b1, 2'd3, 1'b0, 32'h0, 32'h0);
        checkVal("size3_err", 32'(resErr), 1);
        checkVal("size3_strobes", nMemRd + nMemWr + nIoRd + nIoWr, 0);
        idle(1);
        runAccess(1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
        checkVal("mis_h_err", 32'(resErr), 1);
        idle(1);

        // Back-to-back accesses accepted in RESP
        bus.iMemRData = 32'h80FF_1234;
        runAccess(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
        checkVal("b2b_a_data", resData, 32'h80FF_1234);
        checkVal("b2b_a_err", 32'(resErr), 0);
        runAccess(1'b0, 2'd0, 1'b1, 32'h9, 32'h0);
        checkVal("b2b_b_data", resData, 32'h0000_0012);
        checkVal("b2b_b_cyc", nCyc, 3);
        checkVal("b2b_b_rdcyc", nMemRd, 2);
        runAccess(1'b0, 2'd2, 1'b1, 32'hFFFF_FC00, 32'h0);
        checkVal("b2b_c_data", resData, 32'h0000_1111);
        checkVal("b2b_c_cyc", nCyc, 2);
        idle(1);

        // Reset in the middle of MEM_WAIT
        bus.iReq = 1'b1; bus.iWrite = 1'b0; bus.iSize = 2'd2; bus.iAddr = 32'h10;
        @(posedge clk); #1;
        bus.iReq = 1'b0;
        @(negedge clk);
        checkVal("rst_mid_pre_rd", 32'(bus.oMemRead), 1);
        #1 rstN = 1'b0;
        #1;
        checkVal("rst_mid_rd", 32'(bus.oMemRead), 0);
        checkVal("rst_mid_stall", 32'(bus.oStall), 0);
        checkVal("rst_mid_valid", 32'(bus.oValid), 0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.oValid || bus.oStall || bus.oMemRead) seen++;
        end
        rstN = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.oValid || bus.oStall || bus.oMemRead) seen++;
        end
        checkVal("rst_mid_quiet", seen, 0);
        idle(1);
        bus.iMemRData = 32'h0BAD_F00D;
        runAccess(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checkVal("post_rst_data", resData, 32'h0BAD_F00D);
        checkVal("post_rst_rdcyc", nMemRd, 2);
        idle(1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
